// File: rtl/greg_link_pkg.sv
// Shared definitions for the global-register byte link (transmit and receive).
// Frame layout: SYNC, X_center, Y_center, Angle, Zoom, [CSUM].
package greg_link_pkg;

  // Frame delimiter, first byte of every frame
  localparam logic [7:0] GREG_SYNC_BYTE = 8'hA5;

  // Number of payload bytes carried per frame
  localparam int GREG_NUM_DATA = 4;

  // Payload byte positions, shared with the receiving register block
  localparam logic [1:0] GREG_IDX_X     = 2'd0;
  localparam logic [1:0] GREG_IDX_Y     = 2'd1;
  localparam logic [1:0] GREG_IDX_ANGLE = 2'd2;
  localparam logic [1:0] GREG_IDX_ZOOM  = 2'd3;
  localparam logic [1:0] GREG_IDX_LAST  = 2'(GREG_NUM_DATA - 1);

  // Frame sequencer states
  typedef enum logic [1:0] {
    GREG_IDLE = 2'd0,
    GREG_SYNC = 2'd1,
    GREG_DATA = 2'd2,
    GREG_CSUM = 2'd3
  } greg_tx_state_e;

  // Running modulo-256 checksum step
  function automatic logic [7:0] greg_csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/global_regs_frame_tx.sv
// Transmit side of the global-register byte link.
// On Start (sampled only in IDLE) the four register values are snapshotted and
// sent as SYNC, X, Y, Angle, Zoom over a valid/ready byte interface.
// Optional feature macro GREG_TX_CHECKSUM_EN: appends a modulo-256 checksum of
// the four payload bytes (6-byte frame); without it the frame is 5 bytes.
module global_regs_frame_tx
  import greg_link_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = GREG_SYNC_BYTE
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       Start,
  input  logic [7:0] X_center,
  input  logic [7:0] Y_center,
  input  logic [7:0] Angle,
  input  logic [7:0] Zoom,
  output logic [7:0] TByte,
  output logic       TValid,
  input  logic       TReady,
  output logic       Busy,
  output logic       Done
);

  greg_tx_state_e state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [7:0]     x_q, y_q, ang_q, zoom_q;
  logic [7:0]     tbyte_q, tbyte_d;
  logic           tvalid_q, tvalid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           hs_s;
  logic           start_acc_s;

  // A byte moves only when presented and accepted in the same cycle
  assign hs_s        = tvalid_q & TReady;
  assign start_acc_s = (state_q == GREG_IDLE) & Start;

`ifdef GREG_TX_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;

  // Checksum accumulator: cleared on frame start, summed as payload bytes are accepted
  always_comb begin
    acc_d = acc_q;
    if (start_acc_s) begin
      acc_d = 8'h00;
    end else if ((state_q == GREG_DATA) && hs_s) begin
      acc_d = greg_csum_add(acc_q, tbyte_q);
    end else begin
      acc_d = acc_q;
    end
  end

  // Checksum accumulator register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  // Snapshot the register values when a frame is accepted so later input changes cannot leak in
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      x_q    <= 8'h00;
      y_q    <= 8'h00;
      ang_q  <= 8'h00;
      zoom_q <= 8'h00;
    end else if (start_acc_s) begin
      x_q    <= X_center;
      y_q    <= Y_center;
      ang_q  <= Angle;
      zoom_q <= Zoom;
    end else begin
      x_q    <= x_q;
      y_q    <= y_q;
      ang_q  <= ang_q;
      zoom_q <= zoom_q;
    end
  end

  // FSM state register, including payload index
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= GREG_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: advance one byte per handshake, Start honoured only in IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      GREG_IDLE: begin
        if (Start) begin
          state_d = GREG_SYNC;
          idx_d   = 2'd0;
        end else begin
          state_d = GREG_IDLE;
        end
      end
      GREG_SYNC: begin
        if (hs_s) begin
          state_d = GREG_DATA;
          idx_d   = GREG_IDX_X;
        end else begin
          state_d = GREG_SYNC;
        end
      end
      GREG_DATA: begin
        if (hs_s) begin
          if (idx_q == GREG_IDX_LAST) begin
`ifdef GREG_TX_CHECKSUM_EN
            state_d = GREG_CSUM;
`else
            state_d = GREG_IDLE;
`endif
            idx_d = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = GREG_DATA;
        end
      end
      GREG_CSUM: begin
        if (hs_s) begin
          state_d = GREG_IDLE;
        end else begin
          state_d = GREG_CSUM;
        end
      end
      default: begin
        state_d = GREG_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // FSM outputs: next byte is chosen from the next state so it appears the cycle after a handshake
  always_comb begin
    tvalid_d = (state_d != GREG_IDLE);
    busy_d   = (state_d != GREG_IDLE);
    done_d   = (state_q != GREG_IDLE) && (state_d == GREG_IDLE);
    tbyte_d  = 8'h00;
    case (state_d)
      GREG_IDLE: tbyte_d = 8'h00;
      GREG_SYNC: tbyte_d = SYNC_BYTE;
      GREG_DATA: begin
        case (idx_d)
          GREG_IDX_X:     tbyte_d = x_q;
          GREG_IDX_Y:     tbyte_d = y_q;
          GREG_IDX_ANGLE: tbyte_d = ang_q;
          GREG_IDX_ZOOM:  tbyte_d = zoom_q;
          default:        tbyte_d = 8'h00;
        endcase
      end
`ifdef GREG_TX_CHECKSUM_EN
      GREG_CSUM: tbyte_d = acc_d;
`else
      GREG_CSUM: tbyte_d = 8'h00;
`endif
      default:   tbyte_d = 8'h00;
    endcase
  end

  // Registered output stage
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tbyte_q  <= 8'h00;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tbyte_q  <= tbyte_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TByte  = tbyte_q;
  assign TValid = tvalid_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_global_regs_frame_tx.sv
// Scoreboard bench for global_regs_frame_tx. Build with or without
// GREG_TX_CHECKSUM_EN; the reference frame length follows the same macro.
module tb_global_regs_frame_tx;

`ifdef GREG_TX_CHECKSUM_EN
  localparam int LEN = 6;
`else
  localparam int LEN = 5;
`endif

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       Start;
  logic [7:0] X_center, Y_center, Angle, Zoom;
  logic [7:0] TByte;
  logic       TValid, TReady, Busy, Done;

  global_regs_frame_tx dut (
    .ACLK(ACLK), .ARESET(ARESET), .Start(Start),
    .X_center(X_center), .Y_center(Y_center), .Angle(Angle), .Zoom(Zoom),
    .TByte(TByte), .TValid(TValid), .TReady(TReady), .Busy(Busy), .Done(Done)
  );

  always #5 ACLK = ~ACLK;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         bytes_left = 0;
  bit         frame_active = 1'b0;
  bit         expect_done = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  int         done_cyc = -1;
  int         start_cyc = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Reference model: a frame is the delimiter, the four values, then their byte sum
  task automatic push_frame(input logic [7:0] x, y, a, z);
    int sum;
    sum = (int'(x) + int'(y) + int'(a) + int'(z)) % 256;
    exp_q.push_back(8'hA5);
    exp_q.push_back(x);
    exp_q.push_back(y);
    exp_q.push_back(a);
    exp_q.push_back(z);
    if (LEN == 6) exp_q.push_back(8'(sum));
  endtask

  // Monitor: compares every accepted byte, hold-while-stalled, Busy and Done
  always @(negedge ACLK) begin
    logic [7:0] e;
    if (ARESET === 1'b0) begin
      if (expect_done) begin
        vectors++;
        if (Done !== 1'b1 || Busy !== 1'b0 || TValid !== 1'b0) begin
          miscompares++;
          $display("FAIL done_pulse: Done=%b Busy=%b TValid=%b, required 1/0/0", Done, Busy, TValid);
        end
        done_cyc    = cyc;
        expect_done = 1'b0;
      end else if (Done !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: Done=%b at cycle %0d, required 0", Done, cyc);
      end
      if (prev_stall) begin
        vectors++;
        if (TValid !== 1'b1 || TByte !== prev_byte) begin
          miscompares++;
          $display("FAIL hold_stable: TValid=%b TByte=%h, required 1/%h", TValid, TByte, prev_byte);
        end
      end
      vectors++;
      if (Busy !== TValid) begin
        miscompares++;
        $display("FAIL busy_track: Busy=%b, required %b (frame in progress)", Busy, TValid);
      end
      if (TValid === 1'b1 && TReady === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_byte: got %h, required no byte", TByte);
        end else begin
          e = exp_q.pop_front();
          if (TByte !== e) begin
            miscompares++;
            $display("FAIL frame_byte: got %h, required %h", TByte, e);
          end
        end
        if (bytes_left > 0) begin
          bytes_left--;
          if (bytes_left == 0) begin
            frame_active = 1'b0;
            expect_done  = 1'b1;
          end
        end
      end
      prev_stall = (TValid === 1'b1) && (TReady !== 1'b1);
      prev_byte  = TByte;
    end
  end

  // Asynchronous abort: outputs must clear without waiting for a clock edge
  task automatic abort_frame();
    ARESET = 1'b1;
    #1;
    vectors++;
    if (TValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || TByte !== 8'h00) begin
      miscompares++;
      $display("FAIL async_abort: TValid=%b Busy=%b Done=%b TByte=%h, required 0/0/0/00",
               TValid, Busy, Done, TByte);
    end
    exp_q.delete();
    bytes_left   = 0;
    frame_active = 1'b0;
    expect_done  = 1'b0;
    prev_stall   = 1'b0;
    Start        = 1'b0;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  // mode 0: always ready, 1: random backpressure and stray Starts,
  // 2: three-cycle stall on byte 2, 3: reset during Angle, 4: Start held high
  task automatic run_frame(input logic [7:0] x, y, a, z, input int mode);
    int i;
    int exp_done;
    @(posedge ACLK); #1;
    X_center = x; Y_center = y; Angle = a; Zoom = z;
    Start  = 1'b1;
    TReady = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
    push_frame(x, y, a, z);
    bytes_left   = LEN;
    frame_active = 1'b1;
    done_cyc     = -1;
    start_cyc    = cyc + 1;
    @(posedge ACLK); #1;
    vectors++;
    if (TValid !== 1'b1 || TByte !== 8'hA5 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_latency: TValid=%b TByte=%h Busy=%b, required 1/a5/1", TValid, TByte, Busy);
    end
    i = 0;
    while (frame_active && i < 100) begin
      if (mode == 4) Start = 1'b1;
      else if (mode == 1) Start = ($urandom_range(0, 3) == 0);
      else Start = 1'b0;
      X_center = 8'($urandom); Y_center = 8'($urandom);
      Angle    = 8'($urandom); Zoom     = 8'($urandom);
      case (mode)
        1:       TReady = ($urandom_range(0, 2) != 0);
        2:       TReady = !(i >= 2 && i <= 4);
        default: TReady = 1'b1;
      endcase
      if (mode == 3 && i == 3) begin
        abort_frame();
        return;
      end
      i++;
      @(posedge ACLK); #1;
    end
    Start = 1'b0;
    if (frame_active) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: %0d bytes outstanding, required 0", bytes_left);
      abort_frame();
      return;
    end
    @(negedge ACLK); #1;
    vectors++;
    if (Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_done: Busy=%b, required 0", Busy);
    end
    if (mode == 0 || mode == 2 || mode == 4) begin
      exp_done = start_cyc + LEN + ((mode == 2) ? 3 : 0);
      vectors++;
      if (done_cyc != exp_done) begin
        miscompares++;
        $display("FAIL done_timing: Done at cycle %0d, required %0d", done_cyc, exp_done);
      end
    end
  endtask

  initial begin
    ARESET = 1'b1; Start = 1'b0; TReady = 1'b0;
    X_center = 8'h00; Y_center = 8'h00; Angle = 8'h00; Zoom = 8'h00;
    repeat (3) @(posedge ACLK);
    #1;
    vectors++;
    if (TByte !== 8'h00 || TValid !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: TByte=%h TValid=%b Busy=%b Done=%b, required 00/0/0/0",
               TByte, TValid, Busy, Done);
    end
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);

    run_frame(8'h10, 8'h20, 8'h30, 8'h40, 0);
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    run_frame(8'h11, 8'h22, 8'h33, 8'h44, 2);
    run_frame(8'h5A, 8'hC3, 8'h0F, 8'hF0, 4);
    run_frame(8'h01, 8'h02, 8'h03, 8'h04, 3);
    run_frame(8'h10, 8'h20, 8'h30, 8'h40, 0);
    for (int k = 0; k < 40; k++) begin
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                (k % 5 == 0) ? 0 : 1);
      repeat ($urandom_range(0, 2)) @(posedge ACLK);
    end
    repeat (4) @(posedge ACLK);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_bytes: %0d expected bytes never sent, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
